// File: rtl/chmu_epoch_arbiter.sv
// Round-robin address arbiter and epoch sequencer in front of one counter_set instance.
// Optional statistics outputs are enabled by defining CHMU_EPOCH_STATS_EN.
module chmu_epoch_arbiter #(
   parameter int unsigned ADDR_SIZE    = 21,
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned EPOCH_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cfg_enable,
   input  logic [31:0]                    cfg_epoch_cycles,
   input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [ADDR_SIZE-1:0]           cs_addr,
   output logic                           cs_addr_valid,
   output logic                           cs_epoch,
   output logic [EPOCH_W-1:0]             epoch_cnt
`ifdef CHMU_EPOCH_STATS_EN
   ,
   output logic [31:0]                    stat_accept_cnt,
   output logic                           stat_valid
`endif
);

   localparam int unsigned PTR_W  = $clog2(NUM_REQ);
   localparam int unsigned DCNT_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FLUSH
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [31:0]          timer;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     ptr_next;
   logic [DCNT_W-1:0]    drain_cnt;
   logic                 grant_any;
   logic [PTR_W-1:0]     grant_idx;
   logic [PTR_W-1:0]     cand;
   logic [ADDR_SIZE-1:0] grant_addr;
   logic                 run_last;

   // Grants only while RUN with enable still high; dropping enable suppresses that cycle's grant.
   always_comb begin
      req_ready = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (state == RUN && cfg_enable) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
      if (grant_any) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign grant_addr = req_addr[32'(grant_idx)*ADDR_SIZE +: ADDR_SIZE];
   assign ptr_next   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
   assign run_last   = !cfg_enable ||
                       ((cfg_epoch_cycles != '0) && (timer == cfg_epoch_cycles - 32'd1));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cfg_enable) state_next = RUN;
         RUN:     if (run_last) state_next = DRAIN;
         DRAIN:   if (drain_cnt == DCNT_W'(DRAIN_CYCLES - 1)) state_next = FLUSH;
         FLUSH:   state_next = cfg_enable ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // cs_epoch goes through the same output register as cs_addr_valid so the idle gap stays aligned.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         timer         <= '0;
         rr_ptr        <= '0;
         drain_cnt     <= '0;
         cs_addr       <= '0;
         cs_addr_valid <= 1'b0;
         cs_epoch      <= 1'b0;
         epoch_cnt     <= '0;
      end else begin
         state <= state_next;
         if (state != RUN) begin
            timer <= '0;
         end else if (timer != '1) begin
            timer <= timer + 32'd1;
         end
         if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
         end else begin
            drain_cnt <= '0;
         end
         if (grant_any) begin
            rr_ptr  <= ptr_next;
            cs_addr <= grant_addr;
         end
         cs_addr_valid <= grant_any;
         cs_epoch      <= (state == FLUSH);
         if (state == FLUSH) begin
            epoch_cnt <= epoch_cnt + 1'b1;
         end
      end
   end

`ifdef CHMU_EPOCH_STATS_EN
   logic [31:0] accept_acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         accept_acc      <= '0;
         stat_accept_cnt <= '0;
         stat_valid      <= 1'b0;
      end else if (state == FLUSH) begin
         stat_accept_cnt <= accept_acc;
         stat_valid      <= 1'b1;
         accept_acc      <= '0;
      end else begin
         stat_valid <= 1'b0;
         if (grant_any && accept_acc != '1) begin
            accept_acc <= accept_acc + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_chmu_epoch_arbiter.sv
// Directed bench for chmu_epoch_arbiter: cycle model plus address scoreboard, checked each cycle.
module tb_chmu_epoch_arbiter;

   localparam int unsigned AW = 21;
   localparam int unsigned NR = 4;
   localparam int unsigned DC = 3;
   localparam int unsigned EW = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cfg_enable;
   logic [31:0]         cfg_epoch_cycles;
   logic [NR*AW-1:0]    req_addr;
   logic [NR-1:0]       req_valid;
   logic [NR-1:0]       req_ready;
   logic [AW-1:0]       cs_addr;
   logic                cs_addr_valid;
   logic                cs_epoch;
   logic [EW-1:0]       epoch_cnt;
`ifdef CHMU_EPOCH_STATS_EN
   logic [31:0]         stat_accept_cnt;
   logic                stat_valid;
`endif

   always #5 clk = ~clk;

   chmu_epoch_arbiter #(
      .ADDR_SIZE(AW), .NUM_REQ(NR), .DRAIN_CYCLES(DC), .EPOCH_W(EW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cfg_enable(cfg_enable),
      .cfg_epoch_cycles(cfg_epoch_cycles),
      .req_addr(req_addr),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .cs_addr(cs_addr),
      .cs_addr_valid(cs_addr_valid),
      .cs_epoch(cs_epoch),
      .epoch_cnt(epoch_cnt)
`ifdef CHMU_EPOCH_STATS_EN
      ,
      .stat_accept_cnt(stat_accept_cnt),
      .stat_valid(stat_valid)
`endif
   );

   int checks = 0;
   int failures = 0;

   // Reference model: 0 idle, 1 run, 2 drain, 3 flush
   int unsigned   mstate;
   logic [31:0]   mtimer;
   int unsigned   mptr;
   int unsigned   mdrain;
   logic          exp_valid;
   logic          exp_epoch;
   logic [EW-1:0] exp_cnt;
   logic [AW-1:0] sb[$];

   int unsigned   gseq[$];
   int            epoch_pulses;
   int            valid_cycles;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_addr();
      for (int unsigned r = 0; r < NR; r++) req_addr[r*AW +: AW] = AW'($urandom);
   endtask

   task automatic cycle();
      logic [NR-1:0] er;
      logic          ga;
      int unsigned   gi;
      logic [AW-1:0] ea;
      @(negedge clk);
      er = '0;
      ga = 1'b0;
      gi = 0;
      if (mstate == 1 && cfg_enable) begin
         for (int unsigned i = 0; i < NR; i++) begin
            int unsigned c;
            c = (mptr + i) % NR;
            if (!ga && req_valid[c]) begin
               ga = 1'b1;
               gi = c;
            end
         end
      end
      if (ga) er[gi] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(er));
      check("cs_addr_valid", 64'(cs_addr_valid), 64'(exp_valid));
      if (exp_valid && sb.size() > 0) begin
         ea = sb.pop_front();
         check("cs_addr", 64'(cs_addr), 64'(ea));
      end
      check("cs_epoch", 64'(cs_epoch), 64'(exp_epoch));
      check("epoch_cnt", 64'(epoch_cnt), 64'(exp_cnt));
      for (int unsigned b = 0; b < NR; b++) if (req_ready[b] === 1'b1) gseq.push_back(b);
      if (cs_epoch === 1'b1) epoch_pulses++;
      if (cs_addr_valid === 1'b1) valid_cycles++;
      if (ga) sb.push_back(req_addr[gi*AW +: AW]);
      if (!rst_n) begin
         mstate = 0; mtimer = '0; mptr = 0; mdrain = 0;
         exp_valid = 1'b0; exp_epoch = 1'b0; exp_cnt = '0;
         sb.delete();
      end else begin
         exp_valid = ga;
         exp_epoch = (mstate == 3);
         if (mstate == 3) exp_cnt = exp_cnt + 1'b1;
         if (ga) mptr = (gi + 1) % NR;
         case (mstate)
            0: if (cfg_enable) begin mstate = 1; mtimer = '0; end
            1: begin
               if (!cfg_enable || (cfg_epoch_cycles != 0 && mtimer == cfg_epoch_cycles - 1)) begin
                  mstate = 2;
                  mdrain = 0;
               end else if (mtimer != '1) begin
                  mtimer = mtimer + 1;
               end
            end
            2: begin
               mdrain++;
               if (mdrain == DC) mstate = 3;
            end
            default: begin
               mstate = cfg_enable ? 1 : 0;
               mtimer = '0;
            end
         endcase
      end
      @(posedge clk);
      #1;
      randomize_addr();
   endtask

   task automatic clear_obs();
      gseq.delete();
      epoch_pulses = 0;
      valid_cycles = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      clear_obs();
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_enable = 1'b0;
      cfg_epoch_cycles = 32'd8;
      req_valid = '0;
      randomize_addr();
      repeat (2) @(posedge clk);
      #1;
      mstate = 0; mtimer = '0; mptr = 0; mdrain = 0;
      exp_valid = 1'b0; exp_epoch = 1'b0; exp_cnt = '0;
      rst_n = 1'b1;
      clear_obs();

      // Reset state: outputs all zero even with requests pending while disabled
      req_valid = 4'b1111;
      cycle();
      check("reset_outputs", 64'({req_ready, cs_addr_valid, cs_epoch, epoch_cnt}), 64'(0));

      // T1: single requester, 8-cycle epochs
      do_reset();
      cfg_epoch_cycles = 32'd8;
      cfg_enable = 1'b1;
      req_valid = 4'b0001;
      repeat (14) cycle();
      check("t1_valid_cycles", 64'(valid_cycles), 64'd8);
      check("t1_epoch_pulses", 64'(epoch_pulses), 64'd1);
      clear_obs();
      repeat (12) cycle();
      check("t1b_valid_cycles", 64'(valid_cycles), 64'd8);
      check("t1b_epoch_pulses", 64'(epoch_pulses), 64'd1);
      check("t1b_epoch_cnt", 64'(epoch_cnt), 64'd2);

      // T2: all requesters valid from pointer 0
      do_reset();
      req_valid = 4'b1111;
      repeat (10) cycle();
      check("t2_grant_count", 64'(gseq.size()), 64'd8);
      for (int unsigned k = 0; k < 8 && k < gseq.size(); k++)
         check("t2_grant_order", 64'(gseq[k]), 64'(k % NR));

      // T3: requesters 1 and 3 only, pointer moved to 2 first
      do_reset();
      req_valid = 4'b0010;
      cycle();
      cycle();
      req_valid = 4'b1010;
      gseq.delete();
      repeat (4) cycle();
      check("t3_grant_count", 64'(gseq.size()), 64'd4);
      for (int unsigned k = 0; k < 4 && k < gseq.size(); k++)
         check("t3_grant_order", 64'(gseq[k]), (k % 2 == 0) ? 64'd3 : 64'd1);

      // T4: endless epoch
      do_reset();
      cfg_epoch_cycles = 32'd0;
      req_valid = 4'b1111;
      repeat (1000) cycle();
      check("t4_epoch_pulses", 64'(epoch_pulses), 64'd0);
      check("t4_epoch_cnt", 64'(epoch_cnt), 64'd0);
      check("t4_valid_cycles", 64'(valid_cycles), 64'd998);

      // T5: enable dropped on the fourth RUN cycle
      do_reset();
      cfg_epoch_cycles = 32'd8;
      req_valid = 4'b0001;
      repeat (4) cycle();
      cfg_enable = 1'b0;
      repeat (9) cycle();
      check("t5_valid_cycles", 64'(valid_cycles), 64'd3);
      check("t5_epoch_pulses", 64'(epoch_pulses), 64'd1);
      check("t5_idle_ready", 64'(req_ready), 64'd0);

      // T6: reset during DRAIN, then a full epoch from scratch
      cfg_enable = 1'b1;
      do_reset();
      req_valid = 4'b1111;
      repeat (10) cycle();
      do_reset();
      check("t6_post_reset", 64'({req_ready, cs_addr_valid, cs_epoch, epoch_cnt}), 64'(0));
      repeat (13) cycle();
      check("t6_no_pulse", 64'(epoch_pulses), 64'd0);
      cycle();
      check("t6_epoch_pulses", 64'(epoch_pulses), 64'd1);
      check("t6_valid_cycles", 64'(valid_cycles), 64'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
